// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: bus widths, truth and
// direction constants, and the access-size encodings.
package mem_arb_pkg;

  localparam int XLEN   = 32;
  localparam int TYPE_W = 2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  // Access size as carried on ls_type_i / type_o
  typedef enum logic [TYPE_W-1:0] {
    MT_BYTE = 2'b00,
    MT_HALF = 2'b01,
    MT_WORD = 2'b11
  } mem_type_e;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of requester, RAM and instruction-fetch signals around mem_arb.
// master: the arbiter's view. slave: everything surrounding it.
interface mem_arb_if;
  import mem_arb_pkg::*;

  // fetch requester
  logic              if_req_i;
  logic [XLEN-1:0]   if_pc_i;
  logic              if_flush_i;
  logic              if_ok_o;
  logic [XLEN-1:0]   if_inst_o;
  logic [XLEN-1:0]   if_pc_o;

  // load/store requester
  logic              ls_req_i;
  logic              ls_we_i;
  logic [XLEN-1:0]   ls_addr_i;
  logic [XLEN-1:0]   ls_data_i;
  logic [TYPE_W-1:0] ls_type_i;
  logic              ls_signed_i;
  logic              ls_done_o;
  logic [XLEN-1:0]   ls_data_o;

  // downstream data RAM and instruction port
  logic              ram_r_req_o;
  logic              ram_w_req_o;
  logic              inst_fe_o;
  logic [XLEN-1:0]   ram_addr_o;
  logic [XLEN-1:0]   ram_data_o;
  logic [XLEN-1:0]   inst_fpc_o;
  logic [TYPE_W-1:0] type_o;
  logic              ram_done_i;
  logic              inst_ok_i;
  logic [XLEN-1:0]   ram_data_i;
  logic [XLEN-1:0]   inst_i;
  logic [XLEN-1:0]   inst_pc_i;

  modport master (
    input  if_req_i, if_pc_i, if_flush_i,
    output if_ok_o, if_inst_o, if_pc_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_data_i, ls_type_i, ls_signed_i,
    output ls_done_o, ls_data_o,
    output ram_r_req_o, ram_w_req_o, inst_fe_o, ram_addr_o, ram_data_o,
           inst_fpc_o, type_o,
    input  ram_done_i, inst_ok_i, ram_data_i, inst_i, inst_pc_i
  );

  modport slave (
    output if_req_i, if_pc_i, if_flush_i,
    input  if_ok_o, if_inst_o, if_pc_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_data_i, ls_type_i, ls_signed_i,
    input  ls_done_o, ls_data_o,
    input  ram_r_req_o, ram_w_req_o, inst_fe_o, ram_addr_o, ram_data_o,
           inst_fpc_o, type_o,
    output ram_done_i, inst_ok_i, ram_data_i, inst_i, inst_pc_i
  );

endinterface

// File: rtl/mem_arb_ld_ext.sv
// Load extension: picks byte/half/word out of the RAM read data and
// fills the upper bits with zeros or the sign bit.
module mem_ld_ext
  import mem_arb_pkg::*;
(
  input  logic [XLEN-1:0]   data_i,
  input  logic [TYPE_W-1:0] type_i,
  input  logic              signed_i,
  output logic [XLEN-1:0]   data_o
);

  // Size select with optional sign fill; unknown sizes pass through as word
  always_comb begin
    data_o = data_i;
    case (type_i)
      MT_BYTE: data_o = {{(XLEN-8){signed_i & data_i[7]}},   data_i[7:0]};
      MT_HALF: data_o = {{(XLEN-16){signed_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_arb.sv
// Arbiter between instruction fetch and load/store for a single memory
// path. Data wins by default; fetch is forced through after STARVE_LIMIT
// consecutive data grants while it was waiting. A redirect during an
// outstanding fetch discards that fetch's result.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  mem_arb_if.master bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE, ISSUE_D, WAIT_D, ISSUE_I, WAIT_I, RESP
  } state_e;

  state_e              state_q,   state_d;
  logic [CNT_W-1:0]    starve_q,  starve_d;
  logic                discard_q, discard_d;
  logic                we_q,      we_d;
  logic [XLEN-1:0]     addr_q,    addr_d;
  logic [XLEN-1:0]     wdata_q,   wdata_d;
  logic [TYPE_W-1:0]   type_q,    type_d;
  logic                signed_q,  signed_d;
  logic [XLEN-1:0]     pc_q,      pc_d;
  logic                ls_done_q, ls_done_d;
  logic [XLEN-1:0]     ls_data_q, ls_data_d;
  logic                if_ok_q,   if_ok_d;
  logic [XLEN-1:0]     if_inst_q, if_inst_d;
  logic [XLEN-1:0]     if_pc_q,   if_pc_d;

  logic [XLEN-1:0]     ld_data;
  logic                data_ok;
  logic                fetch_ok;
  logic                disc_next;

  mem_ld_ext u_ld_ext (
    .data_i   (bus.ram_data_i),
    .type_i   (type_q),
    .signed_i (signed_q),
    .data_o   (ld_data)
  );

  // Downstream requests decode straight from the ISSUE states; everything
  // else comes from registers so outputs freeze with rdy
  assign bus.ram_r_req_o = (state_q == ISSUE_D) && (we_q == READ);
  assign bus.ram_w_req_o = (state_q == ISSUE_D) && (we_q == WRITE);
  assign bus.inst_fe_o   = (state_q == ISSUE_I);
  assign bus.ram_addr_o  = addr_q;
  assign bus.ram_data_o  = wdata_q;
  assign bus.type_o      = type_q;
  assign bus.inst_fpc_o  = pc_q;
  assign bus.ls_done_o   = ls_done_q;
  assign bus.ls_data_o   = ls_data_q;
  assign bus.if_ok_o     = if_ok_q;
  assign bus.if_inst_o   = if_inst_q;
  assign bus.if_pc_o     = if_pc_q;

  // Next-state, grant decision, request capture and response capture
  always_comb begin
    // NOTE: every _d starts from its hold value, so a branch that does not
    // assign it cannot infer a latch.
    state_d   = state_q;
    starve_d  = starve_q;
    discard_d = discard_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    type_d    = type_q;
    signed_d  = signed_q;
    pc_d      = pc_q;
    ls_done_d = FALSE;
    ls_data_d = ls_data_q;
    if_ok_d   = FALSE;
    if_inst_d = if_inst_q;
    if_pc_d   = if_pc_q;

    data_ok   = bus.ls_req_i && !((starve_q == LIMIT) && bus.if_req_i);
    fetch_ok  = bus.if_req_i && !bus.if_flush_i;
    disc_next = discard_q || bus.if_flush_i;

    case (state_q)
      IDLE: begin
        if (!bus.if_req_i) starve_d = '0;
        if (data_ok) begin
          state_d  = ISSUE_D;
          we_d     = bus.ls_we_i;
          addr_d   = bus.ls_addr_i;
          wdata_d  = bus.ls_data_i;
          type_d   = bus.ls_type_i;
          signed_d = bus.ls_signed_i;
          if (bus.if_req_i && (starve_q != LIMIT)) starve_d = starve_q + 1'b1;
        end else if (fetch_ok) begin
          state_d   = ISSUE_I;
          pc_d      = bus.if_pc_i;
          starve_d  = '0;
          discard_d = FALSE;
        end
      end

      ISSUE_D, WAIT_D: begin
        if (bus.ram_done_i) begin
          state_d   = RESP;
          ls_done_d = TRUE;
          ls_data_d = (we_q == WRITE) ? '0 : ld_data;
        end else begin
          state_d = WAIT_D;
        end
      end

      ISSUE_I, WAIT_I: begin
        if (bus.inst_ok_i) begin
          state_d   = RESP;
          discard_d = FALSE;
          if (!disc_next) begin
            if_ok_d   = TRUE;
            if_inst_d = bus.inst_i;
            if_pc_d   = bus.inst_pc_i;
          end
        end else begin
          state_d   = WAIT_I;
          discard_d = disc_next;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register: synchronous reset, advance only while rdy is high
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value of the others.
    if (rst) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      discard_q <= FALSE;
      we_q      <= READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      type_q    <= '0;
      signed_q  <= FALSE;
      pc_q      <= '0;
      ls_done_q <= FALSE;
      ls_data_q <= '0;
      if_ok_q   <= FALSE;
      if_inst_q <= '0;
      if_pc_q   <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      discard_q <= discard_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      type_q    <= type_d;
      signed_q  <= signed_d;
      pc_q      <= pc_d;
      ls_done_q <= ls_done_d;
      ls_data_q <= ls_data_d;
      if_ok_q   <= if_ok_d;
      if_inst_q <= if_inst_d;
      if_pc_q   <= if_pc_d;
    end
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive data grants allowed while fetch waits.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port rdy  in  1  global enable; when low, all state and outputs hold.
REQ-005 SHALL have ports if_req_i in 1 fetch request (level); if_pc_i in 32 fetch address; if_flush_i in 1 branch-redirect pulse.
REQ-006 SHALL have ports if_ok_o out 1 fetch done pulse; if_inst_o out 32 instruction; if_pc_o out 32 its address.
REQ-007 SHALL have ports ls_req_i in 1 data request (level); ls_we_i in 1 write; ls_addr_i in 32; ls_data_i in 32; ls_type_i in 2 (00 byte, 01 half, 11 word); ls_signed_i in 1 sign-extend loads.
REQ-008 SHALL have ports ls_done_o out 1 data done pulse; ls_data_o out 32 extended load data.
REQ-009 SHALL have downstream ports ram_r_req_o, ram_w_req_o, inst_fe_o out 1; ram_addr_o, ram_data_o, inst_fpc_o out 32; type_o out 2.
REQ-010 SHALL have upstream ports ram_done_i, inst_ok_i in 1; ram_data_i, inst_i, inst_pc_i in 32.

Function
REQ-011 SHALL implement states IDLE, ISSUE_D, WAIT_D, ISSUE_I, WAIT_I, RESP.
REQ-012 SHALL, in IDLE, grant data when ls_req_i=1 unless starve count = STARVE_LIMIT and if_req_i=1; else grant fetch when if_req_i=1; else stay IDLE.
REQ-013 SHALL latch addr/data/type/we of the granted requester at the grant edge; requester inputs are ignored until RESP.
REQ-014 SHALL assert exactly one downstream request (ram_r_req_o, ram_w_req_o or inst_fe_o) for exactly one cycle, in ISSUE_x, then enter WAIT_x with all downstream requests low.
REQ-015 SHALL leave WAIT_D on ram_done_i=1 and WAIT_I on inst_ok_i=1, entering RESP; a done arriving in ISSUE_x (byte write) SHALL be honoured identically.
REQ-016 SHALL in RESP pulse ls_done_o or if_ok_o for one cycle with registered data, ignore all requests, and return to IDLE next cycle.
REQ-017 SHALL extend loads: byte from bits 7:0, half from 15:0, sign- or zero-filled per ls_signed_i; word unchanged; ls_data_o = 0 after writes.
REQ-018 SHALL increment starve count (saturating at STARVE_LIMIT) per data grant while if_req_i=1, and clear it on fetch grant or when if_req_i=0 in IDLE.
REQ-019 SHALL, on if_flush_i in ISSUE_I/WAIT_I, set a discard flag; the completing inst_ok_i then produces no if_ok_o, and the flag clears on leaving WAIT_I.
REQ-020 SHALL, on if_flush_i in IDLE coincident with if_req_i, not grant fetch that cycle; data grant unaffected.
REQ-021 SHALL ignore inst_ok_i in data states and ram_done_i in fetch states.
REQ-022 SHALL hold all outputs and state while rdy=0, including mid-transaction; pulses do not repeat.

Reset
REQ-023 SHALL on rst=1 (with rdy=1) enter IDLE, clear starve count and discard flag, drive every output to 0.
REQ-024 SHALL on reset mid-transaction abandon it with no done pulse; the downstream controller is reset by the same rst.

Structure
REQ-025 SHALL take bus widths, True/False, Read/Write and type encodings from the shared defines header; state encodings stay local.
REQ-026 SHALL place load extension in one combinational sub-module, mem_ld_ext.

Verification
REQ-027 Load word 0x1000, ram_data_i=0x80FF7F01 -> single-cycle ram_r_req_o, type_o=11, ls_done_o one pulse, ls_data_o=0x80FF7F01.
REQ-028 Load byte signed, data 0x000000F0 -> ls_data_o=0xFFFFFFF0; unsigned half, data 0x0000F0F0 -> 0x0000F0F0.
REQ-029 if_req_i and ls_req_i both held, STARVE_LIMIT=4 -> grants D,D,D,D,I,D... ; if_ok_o carries inst_pc_i of the fetch.
REQ-030 Fetch pc 0x200 issued, if_flush_i in WAIT_I -> inst_ok_i consumed, no if_ok_o; new request pc 0x300 then returns if_ok_o with if_pc_o=0x300.
REQ-031 Byte store 0x30000 data 0x41, rdy low 3 cycles in WAIT_D -> outputs frozen, exactly one ram_w_req_o and one ls_done_o.
REQ-032 rst in WAIT_I -> next cycle all outputs 0, state IDLE, no if_ok_o.
